// File: rtl/alarm_sched_pkg.sv
// Shared types and constants for the alarm scheduler: BCD hh:mm time,
// scheduler state encoding and the seconds-per-minute constant.
package alarm_sched_pkg;

  typedef struct packed {
    logic [3:0] hour_tens;
    logic [3:0] hour_ones;
    logic [3:0] min_tens;
    logic [3:0] min_ones;
  } bcd_time_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } sched_state_t;

  localparam int SEC_PER_MIN = 60;

endpackage

// File: rtl/alarm_slot_match.sv
// One alarm slot: stored time/enable, comparator against the running clock,
// and a rising-edge detector that emits a single-cycle trigger.
module alarm_slot_match
  import alarm_sched_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] time_now,
  input  logic        wr_en,
  input  logic [15:0] wr_time,
  input  logic        wr_enable,
  output logic        trigger
);

  bcd_time_t time_reg;
  logic      en_reg;
  logic      match_prev_reg;
  logic      match;

  assign match   = en_reg && (time_reg == bcd_time_t'(time_now));
  // A match held for the whole minute must produce only one trigger.
  assign trigger = match && !match_prev_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      time_reg       <= '0;
      en_reg         <= 1'b0;
      match_prev_reg <= 1'b0;
    end else begin
      match_prev_reg <= match;
      if (wr_en) begin
        time_reg <= bcd_time_t'(wr_time);
        en_reg   <= wr_enable;
      end
    end
  end

endmodule

// File: rtl/alarm_scheduler.sv
// Multi-slot alarm scheduler sharing one buzzer enable through an
// IDLE/RING/SNOOZE FSM. Build option: ALARM_BEEP_PATTERN_EN (1 s on/off beep).
module alarm_scheduler
  import alarm_sched_pkg::*;
#(
  parameter int N_SLOTS    = 4,
  parameter int SNOOZE_MIN = 5,
  parameter int RING_SEC   = 60,
  parameter int MAX_SNOOZE = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sec_tick,
  input  logic [15:0]                time_now,
  input  logic                       cfg_we,
  input  logic [$clog2(N_SLOTS)-1:0] cfg_slot,
  input  logic [15:0]                cfg_time,
  input  logic                       cfg_en,
  input  logic                       stop_btn,
  input  logic                       snooze_btn,
  output logic                       aud_en,
  output logic                       ringing,
  output logic                       snoozed,
  output logic [$clog2(N_SLOTS)-1:0] active_slot
);

  localparam int SLOT_W       = $clog2(N_SLOTS);
  localparam int SEC_W        = 12;
  localparam int SNZ_W        = $clog2(MAX_SNOOZE + 2);
  localparam int SNOOZE_TICKS = SNOOZE_MIN * SEC_PER_MIN;

  logic [N_SLOTS-1:0] trig_vec;
  logic [N_SLOTS-1:0] pending_reg, pending_next;
  logic [SLOT_W-1:0]  pick;
  logic               any_pending;
  logic               cancel;

  sched_state_t       state_reg;
  logic [SLOT_W-1:0]  active_slot_reg;
  logic [SNZ_W-1:0]   snooze_cnt_reg;
  logic [SEC_W-1:0]   sec_cnt_reg;
  logic               aud_en_reg, ringing_reg, snoozed_reg;

  genvar gi;
  generate
    for (gi = 0; gi < N_SLOTS; gi++) begin : g_slot
      alarm_slot_match u_match (
        .clk       (clk),
        .rst       (rst),
        .time_now  (time_now),
        .wr_en     (cfg_we && (cfg_slot == SLOT_W'(gi))),
        .wr_time   (cfg_time),
        .wr_enable (cfg_en),
        .trigger   (trig_vec[gi])
      );
    end
  endgenerate

  always_comb begin
    pick = '0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (pending_reg[i]) pick = SLOT_W'(i);
    end
  end

  assign any_pending = |pending_reg;
  // Reprogramming the slot being served aborts it.
  assign cancel = cfg_we && (state_reg != IDLE) && (cfg_slot == active_slot_reg);

  always_comb begin
    pending_next = pending_reg;
    if (state_reg == IDLE && any_pending) pending_next[pick] = 1'b0;
    if (cancel) pending_next[active_slot_reg] = 1'b0;
    pending_next = pending_next | trig_vec;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending_reg <= '0;
    else     pending_reg <= pending_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      active_slot_reg <= '0;
      snooze_cnt_reg  <= '0;
      sec_cnt_reg     <= '0;
      aud_en_reg      <= 1'b0;
      ringing_reg     <= 1'b0;
      snoozed_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          active_slot_reg <= '0;
          if (any_pending) begin
            state_reg       <= RING;
            active_slot_reg <= pick;
            snooze_cnt_reg  <= '0;
            sec_cnt_reg     <= '0;
            aud_en_reg      <= 1'b1;
            ringing_reg     <= 1'b1;
            snoozed_reg     <= 1'b0;
          end
        end
        RING: begin
          if (cancel || stop_btn) begin
            state_reg       <= IDLE;
            active_slot_reg <= '0;
            sec_cnt_reg     <= '0;
            aud_en_reg      <= 1'b0;
            ringing_reg     <= 1'b0;
            snoozed_reg     <= 1'b0;
          end else if (snooze_btn && (snooze_cnt_reg < SNZ_W'(MAX_SNOOZE))) begin
            state_reg      <= SNOOZE;
            snooze_cnt_reg <= snooze_cnt_reg + SNZ_W'(1);
            sec_cnt_reg    <= '0;
            aud_en_reg     <= 1'b0;
            ringing_reg    <= 1'b0;
            snoozed_reg    <= 1'b1;
          end else if (sec_tick) begin
            if (sec_cnt_reg == SEC_W'(RING_SEC - 1)) begin
              state_reg       <= IDLE;
              active_slot_reg <= '0;
              sec_cnt_reg     <= '0;
              aud_en_reg      <= 1'b0;
              ringing_reg     <= 1'b0;
              snoozed_reg     <= 1'b0;
            end else begin
              sec_cnt_reg <= sec_cnt_reg + SEC_W'(1);
`ifdef ALARM_BEEP_PATTERN_EN
              aud_en_reg  <= ~aud_en_reg;
`endif
            end
          end
        end
        SNOOZE: begin
          if (cancel || stop_btn) begin
            state_reg       <= IDLE;
            active_slot_reg <= '0;
            sec_cnt_reg     <= '0;
            aud_en_reg      <= 1'b0;
            ringing_reg     <= 1'b0;
            snoozed_reg     <= 1'b0;
          end else if (sec_tick) begin
            if (sec_cnt_reg == SEC_W'(SNOOZE_TICKS - 1)) begin
              state_reg   <= RING;
              sec_cnt_reg <= '0;
              aud_en_reg  <= 1'b1;
              ringing_reg <= 1'b1;
              snoozed_reg <= 1'b0;
            end else begin
              sec_cnt_reg <= sec_cnt_reg + SEC_W'(1);
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign aud_en      = aud_en_reg;
  assign ringing     = ringing_reg;
  assign snoozed     = snoozed_reg;
  assign active_slot = active_slot_reg;

endmodule

// File: tb/tb_alarm_scheduler.sv
// Self-checking bench for alarm_scheduler: event-level reference model compared
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_alarm_scheduler;

  localparam int N     = 4;
  localparam int SMIN  = 5;
  localparam int RSEC  = 60;
  localparam int MAXS  = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sec_tick = 1'b0;
  logic [15:0] time_now = 16'h0000;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_slot = 2'd0;
  logic [15:0] cfg_time = 16'h0000;
  logic        cfg_en = 1'b0;
  logic        stop_btn = 1'b0;
  logic        snooze_btn = 1'b0;
  logic        aud_en, ringing, snoozed;
  logic [1:0]  active_slot;

  alarm_scheduler #(
    .N_SLOTS(N), .SNOOZE_MIN(SMIN), .RING_SEC(RSEC), .MAX_SNOOZE(MAXS)
  ) dut (
    .clk(clk), .rst(rst), .sec_tick(sec_tick), .time_now(time_now),
    .cfg_we(cfg_we), .cfg_slot(cfg_slot), .cfg_time(cfg_time), .cfg_en(cfg_en),
    .stop_btn(stop_btn), .snooze_btn(snooze_btn),
    .aud_en(aud_en), .ringing(ringing), .snoozed(snoozed), .active_slot(active_slot)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_on   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // aud_en expected while ringing, given sec_ticks seen since RING entry
  function automatic logic exp_aud(input int ticks);
`ifdef ALARM_BEEP_PATTERN_EN
    return (ticks % 2) == 0;
`else
    return 1'b1;
`endif
  endfunction

  // ---------------- reference model (mode: 0 idle, 1 ring, 2 snooze) ----------------
  logic [15:0] m_t[N];
  bit m_en[N], m_prev[N], m_pend[N], m_trig[N];
  bit m_match, m_found;
  int m_mode = 0, m_act = 0, m_snz = 0, m_cnt = 0;
  bit m_beep = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_t[i] = 16'h0; m_en[i] = 1'b0; m_prev[i] = 1'b0; m_pend[i] = 1'b0;
      end
      m_mode = 0; m_act = 0; m_snz = 0; m_cnt = 0; m_beep = 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        m_match   = m_en[i] && (m_t[i] == time_now);
        m_trig[i] = m_match && !m_prev[i];
        m_prev[i] = m_match;
      end
      if (m_mode == 0) begin
        m_act = 0;
        m_found = 1'b0;
        for (int i = 0; i < N; i++) begin
          if (!m_found && m_pend[i]) begin
            m_found = 1'b1; m_act = i; m_pend[i] = 1'b0;
            m_mode = 1; m_cnt = 0; m_snz = 0; m_beep = 1'b1;
          end
        end
      end else if (cfg_we && int'(cfg_slot) == m_act) begin
        m_pend[m_act] = 1'b0; m_mode = 0; m_act = 0;
      end else if (stop_btn) begin
        m_mode = 0; m_act = 0;
      end else if (m_mode == 1 && snooze_btn && m_snz < MAXS) begin
        m_mode = 2; m_snz++; m_cnt = 0;
      end else if (sec_tick) begin
        m_cnt++;
        if (m_mode == 1) begin
          if (m_cnt == RSEC) begin
            m_mode = 0; m_act = 0;
          end else begin
`ifdef ALARM_BEEP_PATTERN_EN
            m_beep = !m_beep;
`endif
          end
        end else if (m_cnt == SMIN * 60) begin
          m_mode = 1; m_cnt = 0; m_beep = 1'b1;
        end
      end
      for (int i = 0; i < N; i++) if (m_trig[i]) m_pend[i] = 1'b1;
      if (cfg_we) begin
        m_t[cfg_slot] = cfg_time; m_en[cfg_slot] = cfg_en;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on && !rst)
      check("model_outputs", {aud_en, ringing, snoozed, active_slot},
            {(m_mode == 1) && m_beep, m_mode == 1, m_mode == 2, m_act[1:0]});
  end

  // ---------------- stimulus helpers (inputs change on negedge) ----------------
  task automatic cfg_write(input logic [1:0] s, input logic [15:0] t, input logic e);
    cfg_slot = s; cfg_time = t; cfg_en = e; cfg_we = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic pulse_tick();
    sec_tick = 1'b1; @(negedge clk); sec_tick = 1'b0; @(negedge clk);
  endtask

  task automatic press(input logic stop_v, input logic snz_v);
    stop_btn = stop_v; snooze_btn = snz_v; @(negedge clk);
    stop_btn = 1'b0; snooze_btn = 1'b0;
  endtask

  initial begin
    time_now = 16'h0729;
    repeat (3) @(negedge clk);
    rst = 1'b0; chk_on = 1'b1;
    check("reset_outputs", {aud_en, ringing, snoozed, active_slot}, 5'b0);

    // single slot trigger, latency, auto-stop, no re-trigger
    cfg_write(2'd1, 16'h0730, 1'b1);
    @(negedge clk);
    time_now = 16'h0730;
    @(negedge clk);
    check("t1_latency_1cyc_aud", aud_en, 1'b0);
    @(negedge clk);
    check("t1_latency_2cyc_aud", aud_en, 1'b1);
    check("t1_active_slot", active_slot, 2'd1);
    for (int k = 1; k < RSEC; k++) begin
      pulse_tick();
      check("t1_ring_aud", {ringing, aud_en}, {1'b1, exp_aud(k)});
    end
    pulse_tick();
    check("t1_timeout_idle", {ringing, aud_en}, 2'b00);
    repeat (5) @(negedge clk);
    check("t1_no_retrigger", ringing, 1'b0);

    // two slots on the same minute: lowest index first
    cfg_write(2'd1, 16'h0730, 1'b0);
    cfg_write(2'd0, 16'h0600, 1'b1);
    cfg_write(2'd2, 16'h0600, 1'b1);
    time_now = 16'h0600;
    repeat (2) @(negedge clk);
    check("t2_first_slot0", {ringing, active_slot}, {1'b1, 2'd0});
    press(1'b1, 1'b0);
    check("t2_stop_idle", ringing, 1'b0);
    @(negedge clk);
    check("t2_then_slot2", {ringing, active_slot}, {1'b1, 2'd2});
    press(1'b1, 1'b0);
    check("t2_stop2_idle", ringing, 1'b0);

    // snooze cycles, snooze limit
    cfg_write(2'd3, 16'h0800, 1'b1);
    time_now = 16'h0800;
    repeat (2) @(negedge clk);
    check("t3_ring_slot3", {ringing, active_slot}, {1'b1, 2'd3});
    for (int s = 1; s <= MAXS; s++) begin
      press(1'b0, 1'b1);
      check("t3_snoozed", {aud_en, ringing, snoozed}, 3'b001);
      repeat (SMIN * 60 - 1) pulse_tick();
      check("t3_still_snoozed_299", snoozed, 1'b1);
      pulse_tick();
      check("t3_ring_after_300", {aud_en, ringing, snoozed}, 3'b110);
    end
    press(1'b0, 1'b1);
    check("t3_snooze_ignored", {ringing, snoozed}, 2'b10);
    press(1'b1, 1'b0);
    check("t3_stop_idle", {ringing, snoozed, active_slot}, 4'b0);

    // stop beats snooze
    time_now = 16'h0600;
    repeat (2) @(negedge clk);
    check("t4_ring_slot0", {ringing, active_slot}, {1'b1, 2'd0});
    press(1'b1, 1'b1);
    check("t4_stop_wins", {ringing, snoozed}, 2'b00);
    @(negedge clk);
    check("t4_slot2_next", {ringing, active_slot}, {1'b1, 2'd2});

    // config write to the snoozing slot cancels it
    press(1'b0, 1'b1);
    check("t5_snoozed", snoozed, 1'b1);
    repeat (3) @(negedge clk);
    cfg_write(2'd2, 16'h0900, 1'b1);
    check("t5_cancel_idle", {ringing, snoozed, active_slot}, 4'b0);
    repeat (3) @(negedge clk);
    check("t5_stays_idle", ringing, 1'b0);

    // asynchronous reset mid-ring clears outputs and pending mask
    cfg_write(2'd1, 16'h1000, 1'b1);
    cfg_write(2'd3, 16'h1000, 1'b1);
    time_now = 16'h1000;
    repeat (2) @(negedge clk);
    check("t6_ring_slot1", {ringing, active_slot}, {1'b1, 2'd1});
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t6_async_reset", {aud_en, ringing, snoozed, active_slot}, 5'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("t6_pending_cleared", ringing, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alarm_scheduler.md
Name: alarm_scheduler

Overview:
Multi-slot alarm controller that shares the single buzzer enable between N programmable alarm slots. It compares each enabled slot against the current BCD hh:mm time and queues triggered slots. It then serves them one at a time through a RING/SNOOZE state machine with stop, snooze and ring-timeout handling. It sits between the clock/time-keeping logic and the audio generator, and drives the audio generator's enable.

Parameters:
N_SLOTS, 4, number of alarm slots (2..8)
SNOOZE_MIN, 5, snooze length in minutes (1..59)
RING_SEC, 60, auto-stop timeout while ringing, in seconds (1..255)
MAX_SNOOZE, 3, snoozes allowed per trigger; further snooze presses are ignored

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
sec_tick  in  1  one-cycle pulse, once per second
time_now  in  16  current time {hourdec,hourone,mindec,minone}, BCD
cfg_we  in  1  slot write strobe
cfg_slot  in  $clog2(N_SLOTS)  slot index for the write
cfg_time  in  16  slot alarm time, BCD, same packing as time_now
cfg_en  in  1  slot enable written with cfg_we
stop_btn  in  1  stop request, single-cycle pulse (debounced upstream)
snooze_btn  in  1  snooze request, single-cycle pulse
aud_en  out  1  buzzer enable
ringing  out  1  high in RING
snoozed  out  1  high in SNOOZE
active_slot  out  $clog2(N_SLOTS)  slot being served; 0 in IDLE

Behaviour:
- Reset: all slot times = 0, all slot enables = 0, pending mask = 0, state = IDLE. aud_en, ringing, snoozed, active_slot, timers and snooze count are all 0.
- Slot config: cfg_we writes time and enable of cfg_slot in that cycle. If cfg_slot is the slot in RING or SNOOZE, the write cancels it: next state IDLE, pending bit cleared.
- Trigger: per slot, match = en && (slot_time == time_now). A slot's pending bit is set on the rising edge of match (registered previous match), one cycle after the match is first seen. Match held for the whole minute gives one trigger only. Writing a slot time equal to time_now triggers it.
- Pending bits accumulate while the scheduler is busy.
- States:
  - IDLE: if any pending bit is set, take the lowest index. active_slot <= index, clear its bit, snooze count <= 0, go to RING. Latency: aud_en is high 1 cycle after the pending bit is set.
  - RING: aud_en = 1.
    - stop_btn -> IDLE.
    - snooze_btn with count < MAX_SNOOZE -> SNOOZE, count++.
    - snooze_btn with count == MAX_SNOOZE is ignored.
    - RING_SEC sec_ticks counted since entry -> IDLE (auto-stop).
  - SNOOZE: aud_en = 0.
    - Counts SNOOZE_MIN*60 sec_ticks, then -> RING with the ring timer restarted.
    - stop_btn -> IDLE.
    - snooze_btn is ignored.
- Simultaneous events: stop_btn beats snooze_btn. A button beats sec_tick in the same cycle. A cfg cancel beats both buttons.
- Timers are cleared on every state entry. The second counter is wide enough for SNOOZE_MIN*60 (12 bits).
- Buttons in IDLE are ignored. No pending bit is lost while busy. A slot re-triggering while already pending stays pending (no double count).
- Outputs are registered. ringing/snoozed/aud_en reflect the current state.

Optional Feature:
ALARM_BEEP_PATTERN_EN:
- Defined: in RING, aud_en toggles on each sec_tick (1 s on / 1 s off), starting at 1 on RING entry.
- Undefined: aud_en is continuously 1 in RING.
- All other behaviour is identical in both builds.

Decomposition:
- Package alarm_sched_pkg: BCD time typedef (struct of four 4-bit digits, 16 bits packed), state enum {IDLE, RING, SNOOZE}, constant SEC_PER_MIN = 60.
- Sub-module alarm_slot_match, one instance per slot: holds the slot's time and enable registers, the match comparator and the rising-edge detector. It outputs a one-cycle trigger.
- Top level holds the pending mask, the lowest-index priority pick, the FSM and the timers.

Test Plan:
- Slot 1 = 07:30 enabled, time_now steps 07:29 -> 07:30 -> aud_en=1 two cycles after the step and active_slot=1. With no buttons, aud_en=0 after the 60th sec_tick. No re-trigger while time_now stays 07:30.
- Slots 0 and 2 both = 06:00 -> slot 0 rings first. stop_btn -> IDLE, then slot 2 rings the next cycle.
- Ringing slot, snooze_btn -> aud_en=0 and snoozed=1. After exactly 300 sec_ticks, ringing=1 again. On the 4th ring, snooze_btn is ignored; stop_btn -> IDLE.
- stop_btn and snooze_btn in the same cycle while ringing -> IDLE, snoozed stays 0.
- cfg_we to the active slot during SNOOZE -> IDLE next cycle. rst asserted mid-RING -> all outputs 0 immediately, pending mask cleared.
- With ALARM_BEEP_PATTERN_EN: a ring of 6 sec_ticks shows aud_en pattern 1,0,1,0,1,0.
